uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the frame data bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, giving the width of the internal DATA-phase counter; it SHALL hold DATA_WIDTH+1.
REQ-003 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port P_DATA, input, DATA_WIDTH, the frame payload, sampled on acceptance.
REQ-006 SHALL have port DATA_VALID, input, 1, a frame request.
REQ-007 SHALL have port PAR_EN, input, 1, parity enable, sampled on acceptance.
REQ-008 SHALL have port PAR_TYP, input, 1, parity type (0 even, 1 odd), sampled on acceptance.
REQ-009 SHALL have port SER_DONE, input, 1, the serializer's last-data-bit flag.
REQ-010 SHALL have port SER_LOAD, output, 1, the serializer load strobe (drives serializer DATA_VALID).
REQ-011 SHALL have port SER_EN, output, 1, the serializer shift enable.
REQ-012 SHALL have port MUX_SEL, output, 2, the line mux select: 00 start(0), 01 stop/idle(1), 10 serial data, 11 parity.
REQ-013 SHALL have port PAR_BIT, output, 1, the computed parity bit.
REQ-014 SHALL have port BUSY, output, 1, high while a frame is in progress.
REQ-015 SHALL have port TIMEOUT, output, 1, a one-cycle pulse when the serializer fails to finish.

Function
REQ-016 SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-017 SHALL accept a frame when DATA_VALID=1 in IDLE or STOP; SER_LOAD SHALL be DATA_VALID AND (state IDLE or STOP), combinational.
REQ-018 SHALL, on the acceptance edge, register PAR_EN, PAR_TYP and PAR_BIT = (XOR of P_DATA) XOR PAR_TYP; the next state SHALL be START.
REQ-019 SHALL ignore PAR_EN, PAR_TYP and P_DATA changes mid-frame.
REQ-020 SHALL hold START exactly one cycle: MUX_SEL=00, SER_EN=1, then DATA.
REQ-021 DATA state SHALL drive MUX_SEL=10 and SER_EN=1 every cycle.
REQ-022 SHALL leave DATA on the cycle SER_DONE=1, going to PARITY if the latched PAR_EN=1, else STOP; nominal DATA length is DATA_WIDTH cycles.
REQ-023 SHALL count DATA cycles; if the count reaches DATA_WIDTH+1 without SER_DONE, it SHALL pulse TIMEOUT for one cycle and go to STOP.
REQ-024 SHALL clear the counter on entry to DATA.
REQ-025 SHALL hold PARITY exactly one cycle: MUX_SEL=11, SER_EN=0, then STOP.
REQ-026 SHALL hold STOP exactly one cycle: MUX_SEL=01, SER_EN=0, then START if a frame is accepted (back-to-back, no idle gap), else IDLE.
REQ-027 SHALL drive MUX_SEL=01, SER_EN=0 and BUSY=0 in IDLE.
REQ-028 SHALL drive BUSY=1 in START, DATA, PARITY and STOP.
REQ-029 SHALL make the frame length 11 cycles with parity and 10 cycles without (DATA_WIDTH=8).
REQ-030 SHALL ignore SER_DONE outside DATA.

Reset
REQ-031 SHALL, with RST=1 at a rising edge, set state IDLE, counter 0, PAR_BIT=0, latched PAR_EN/PAR_TYP=0 and TIMEOUT=0.
REQ-032 SHALL force SER_LOAD=0, SER_EN=0, BUSY=0 and MUX_SEL=01 while RST=1.
REQ-033 SHALL abandon any frame in progress on reset mid-frame, with no STOP cycle emitted.
REQ-034 SHALL give RST priority over DATA_VALID in the same cycle.

Configuration
REQ-035 SHALL use macro UART_TX_PARITY_EN: when defined, the PARITY state and PAR_BIT logic exist per REQ-018/022/025.
REQ-036 SHALL, when UART_TX_PARITY_EN is undefined, have no PARITY state: DATA always goes to STOP, PAR_BIT is tied 0, and PAR_EN/PAR_TYP are ignored (ports retained).

Verification
REQ-037 Reset, then P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID, serializer model SER_DONE on DATA cycle 8 -> MUX_SEL 00, 10x8, 11, 01; PAR_BIT=0; BUSY high 11 cycles.
REQ-038 P_DATA=0x07, PAR_EN=1, PAR_TYP=1 -> PAR_BIT=0; with PAR_EN=0 -> no 11 cycle, BUSY high 10 cycles.
REQ-039 DATA_VALID held high for two frames -> STOP followed directly by START, SER_LOAD pulses in IDLE and in STOP, 22 busy cycles.
REQ-040 SER_DONE never asserted -> TIMEOUT one-cycle pulse after 9 DATA cycles, then STOP, then IDLE.
REQ-041 RST=1 during DATA cycle 4 -> next cycle IDLE, MUX_SEL=01, BUSY=0; simultaneous RST and DATA_VALID -> no SER_LOAD.
REQ-042 Build without UART_TX_PARITY_EN, PAR_EN=1 -> MUX_SEL never 11, PAR_BIT=0, 10-cycle frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop and drives the serializer and line mux.
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  SER_DONE,
  output logic                  SER_LOAD,
  output logic                  SER_EN,
  output logic [1:0]            MUX_SEL,
  output logic                  PAR_BIT,
  output logic                  BUSY,
  output logic                  TIMEOUT
);

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_timeout;
  logic                 w_timeout;
  logic                 w_accept;
  logic                 w_en;
  logic                 w_busy;
  logic [1:0]           w_mux;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;
  assign PAR_BIT = r_par_bit;
`else
  logic w_unused_par;
  assign w_unused_par = ^{P_DATA, PAR_EN, PAR_TYP};
  assign PAR_BIT      = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_mux     = 2'b01;
    w_en      = 1'b0;
    w_busy    = 1'b0;
    w_timeout = 1'b0;
    w_accept  = DATA_VALID && (r_state == S_IDLE || r_state == S_STOP);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_START;
      end
      S_START: begin
        w_mux  = 2'b00;
        w_en   = 1'b1;
        w_busy = 1'b1;
        w_next = S_DATA;
      end
      S_DATA: begin
        w_mux  = 2'b10;
        w_en   = 1'b1;
        w_busy = 1'b1;
        if (SER_DONE) begin
`ifdef UART_TX_PARITY_EN
          w_next = r_par_en ? S_PARITY : S_STOP;
`else
          w_next = S_STOP;
`endif
        end else if (r_cnt == LP_LAST) begin
          // Serializer overran by one cycle: abort straight to STOP.
          w_timeout = 1'b1;
          w_next    = S_STOP;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_mux  = 2'b11;
        w_busy = 1'b1;
        w_next = S_STOP;
      end
`endif
      S_STOP: begin
        w_busy = 1'b1;
        w_next = w_accept ? S_START : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset gates the outputs combinationally so nothing leaks while it is held.
  assign SER_LOAD = w_accept && !RST;
  assign SER_EN   = w_en && !RST;
  assign BUSY     = w_busy && !RST;
  assign MUX_SEL  = RST ? 2'b01 : w_mux;
  assign TIMEOUT  = r_timeout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_timeout;
      if (r_state == S_DATA) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_accept) begin
      r_par_en  <= PAR_EN;
      r_par_bit <= (^P_DATA) ^ PAR_TYP;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle stimulus/expectation queues plus a serializer model.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       SER_DONE;
  logic       SER_LOAD, SER_EN, PAR_BIT, BUSY, TIMEOUT;
  logic [1:0] MUX_SEL;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .SER_DONE(SER_DONE),
    .SER_LOAD(SER_LOAD), .SER_EN(SER_EN), .MUX_SEL(MUX_SEL),
    .PAR_BIT(PAR_BIT), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Serializer model: flags its last bit on the 8th data cycle unless hung.
  int   dcnt = 1;
  logic hang = 1'b0;
  always @(posedge CLK) dcnt <= (MUX_SEL == 2'b10) ? dcnt + 1 : 1;
  assign SER_DONE = !hang && (MUX_SEL == 2'b10) && (dcnt == 8);

  typedef struct packed {logic rst; logic dv; logic [7:0] d; logic pen; logic ptyp;} stim_t;
  typedef struct packed {logic load; logic [1:0] mux; logic busy; logic en; logic to;} exp_t;
  typedef struct {logic [7:0] d; logic pen; logic ptyp; logic par;} vec_t;

  stim_t sq[$];
  exp_t  eq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic stim_t st(input logic rst, dv, input logic [7:0] d, input logic pen, ptyp);
    st = {rst, dv, d, pen, ptyp};
  endfunction

  function automatic exp_t ex(input logic load, input logic [1:0] mux, input logic busy, en, to);
    ex = {load, mux, busy, en, to};
  endfunction

  task automatic cyc(input stim_t s, input exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic accept(input logic [7:0] d, input logic pen, ptyp);
    cyc(st(1'b0, 1'b1, d, pen, ptyp), ex(1'b1, 2'b01, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic idle();
    cyc(st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0), ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
  endtask

  // START..STOP; inputs are scrambled mid-frame, STOP may carry the next request.
  task automatic body(input logic [7:0] d, input logic pen, ptyp, input bit hung,
                      input logic ndv, input logic [7:0] nd, input logic npen, nptyp);
    stim_t junk;
    junk = st(1'b0, 1'b0, ~d, ~pen, ~ptyp);
    cyc(junk, ex(1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < (hung ? 9 : 8); i++) cyc(junk, ex(1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
    if (HAS_PAR && pen && !hung) cyc(junk, ex(1'b0, 2'b11, 1'b1, 1'b0, 1'b0));
    cyc(st(1'b0, ndv, nd, npen, nptyp), ex(ndv, 2'b01, 1'b1, 1'b0, hung));
  endtask

  task automatic run(input string name);
    stim_t s;
    exp_t  e, got;
    int    k;
    k = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      {RST, DATA_VALID, P_DATA, PAR_EN, PAR_TYP} = s;
      @(negedge CLK);
      e   = eq.pop_front();
      got = {SER_LOAD, MUX_SEL, BUSY, SER_EN, TIMEOUT};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: load/mux/busy/en/to got %b required %b", name, k, got, e);
      end
      k++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_par(input string name, input logic want);
    n_checks++;
    if (PAR_BIT !== want) begin
      n_fail++;
      $display("FAIL %s PAR_BIT got %b required %b", name, PAR_BIT, want);
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1};

    @(posedge CLK);
    #1;

    // Reset held with a simultaneous request: no load, idle outputs.
    cyc(st(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1), ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
    cyc(st(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1), ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
    idle();
    run("reset");
    check_par("reset", 1'b0);

    foreach (vecs[i]) begin
      accept(vecs[i].d, vecs[i].pen, vecs[i].ptyp);
      body(vecs[i].d, vecs[i].pen, vecs[i].ptyp, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle();
      run($sformatf("vec%0d", i));
      check_par($sformatf("vec%0d", i), HAS_PAR ? vecs[i].par : 1'b0);
    end

    // Back-to-back frames: STOP accepts the next request directly.
    accept(8'hA5, 1'b1, 1'b0);
    body(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0);
    body(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    run("b2b");
    check_par("b2b", HAS_PAR ? 1'b1 : 1'b0);

    // Hung serializer: 9 data cycles, TIMEOUT during STOP, then idle.
    hang = 1'b1;
    accept(8'h3C, 1'b1, 1'b0);
    body(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    idle();
    run("timeout");
    hang = 1'b0;

    // Reset on data cycle 4 with a request pending: frame dropped, no load.
    accept(8'h07, 1'b1, 1'b0);
    cyc(st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0), ex(1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc(st(1'b0, 1'b0, 8'h00, 1'b0, 1'b0), ex(1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
    cyc(st(1'b1, 1'b1, 8'h07, 1'b1, 1'b0), ex(1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
    idle();
    idle();
    run("midreset");
    check_par("midreset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
